// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and helpers for the HUB75 BCM scanner.
//   state_e  - top-level scan FSM states
//   phase_e  - per-column sub-phases inside SHIFT
//   CH_R/G/B - channel slice index; a channel occupies rd_data[CH_x*BPC +: BPC]
//   f_aw     - address width of a count (min 1 bit), used for ROW_AW and COL_AW
//   f_ont_w  - on-time counter width, $clog2(BASE_OE << (BPC-1)) + 1 (ONT_W)
package hub75_pkg;

   typedef enum logic [1:0] {StIdle, StShift, StLatch, StShow} state_e;

   typedef enum logic [2:0] {PhFetch, PhLoad, PhSetup, PhHigh, PhLow} phase_e;

   localparam int unsigned CH_R = 2;
   localparam int unsigned CH_G = 1;
   localparam int unsigned CH_B = 0;

   function automatic int unsigned f_aw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned f_ont_w(input int unsigned base_oe, input int unsigned bpc);
      return $clog2(base_oe << (bpc - 1)) + 1;
   endfunction

endpackage

// File: rtl/hub75_bcm_scanner_if.sv
// hub75_bcm_scanner_if: framebuffer read port and HUB75 panel pins.
//   master (scanner side): drives rd_en/rd_row/rd_col and all panel pins, reads rd_data0/1.
//   slave  (framebuffer + panel side): the mirror image.
//   rd_data0/1 carry {R,G,B}, each BPC bits, valid one cycle after rd_en.
interface hub75_bcm_scanner_if #(
   parameter int unsigned COLS = 64,
   parameter int unsigned ROWS = 32,
   parameter int unsigned BPC  = 4
);
   import hub75_pkg::*;

   localparam int unsigned ROW_AW = f_aw(ROWS / 2);
   localparam int unsigned COL_AW = f_aw(COLS);

   logic                  rd_en;
   logic [ROW_AW-1:0]     rd_row;
   logic [COL_AW-1:0]     rd_col;
   logic [3*BPC-1:0]      rd_data0;
   logic [3*BPC-1:0]      rd_data1;
   logic [ROW_AW-1:0]     addr;
   logic                  r0, g0, b0, r1, g1, b1;
   logic                  clk_shft;
   logic                  lat;
   logic                  oe;
   logic                  frame_done;

   modport master (
      output rd_en, rd_row, rd_col, addr, r0, g0, b0, r1, g1, b1, clk_shft, lat, oe,
             frame_done,
      input  rd_data0, rd_data1
   );

   modport slave (
      input  rd_en, rd_row, rd_col, addr, r0, g0, b0, r1, g1, b1, clk_shft, lat, oe,
             frame_done,
      output rd_data0, rd_data1
   );

endinterface

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: BCM on-time window for one bit-plane.
//   i_load  - start a window of BASE_OE << i_plane cycles (first window cycle follows i_load)
//   i_plane - bit-plane index
//   i_dim   - global brightness 0..255, sampled on i_load (only with GLOBAL_DIM_EN)
//   o_oe_n  - active-low output enable, low for the first on-time cycles of the window
//   o_done  - high in the last cycle of the window
// Optional feature macro: GLOBAL_DIM_EN scales the on-time by i_dim/256 at a fixed window length.
module hub75_bcm_timer #(
   parameter int unsigned BASE_OE = 64,
   parameter int unsigned ONT_W   = 10,
   parameter int unsigned PL_W    = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load,
   input  logic [PL_W-1:0] i_plane,
`ifdef GLOBAL_DIM_EN
   input  logic [7:0]      i_dim,
`endif
   output logic            o_oe_n,
   output logic            o_done
);

   logic [ONT_W-1:0] w_len;
   logic [ONT_W-1:0] w_on;
   logic [ONT_W-1:0] r_win;
   logic [ONT_W-1:0] r_on;

   assign w_len = ONT_W'(BASE_OE) << i_plane;

`ifdef GLOBAL_DIM_EN
   localparam int unsigned PW = ONT_W + 8;
   logic [PW-1:0] w_prod;
   assign w_prod = PW'(w_len) * PW'(i_dim);
   assign w_on   = w_prod[PW-1:8];
`else
   assign w_on = w_len;
`endif

   // Both counters run down together; r_win sets the window, r_on the lit portion.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_win <= '0;
         r_on  <= '0;
      end else if (i_load) begin
         r_win <= w_len;
         r_on  <= w_on;
      end else begin
         if (r_win != '0) r_win <= r_win - 1'b1;
         if (r_on != '0)  r_on  <= r_on - 1'b1;
      end
   end

   assign o_oe_n = (r_on == '0);
   assign o_done = (r_win == ONT_W'(1));

endmodule

// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 row-pair scanner with binary-coded-modulation colour depth.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_enable       - run scanning; checked at row-pair boundaries
//   i_dim          - global brightness (only with GLOBAL_DIM_EN)
//   bus            - hub75_bcm_scanner_if.master: framebuffer read port + panel pins
// Per column: Fetch (rd_en), Load (capture plane bit), Setup (data settles before the
// rising edge), High x CLK_DIV, Low x CLK_DIV. Then LATCH (2 cycles LAT + 1 gap), then SHOW.
// Optional feature macro: GLOBAL_DIM_EN.
module hub75_bcm_scanner
   import hub75_pkg::*;
#(
   parameter int unsigned COLS    = 64,
   parameter int unsigned ROWS    = 32,
   parameter int unsigned BPC     = 4,
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned BASE_OE = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_enable,
`ifdef GLOBAL_DIM_EN
   input  logic [7:0]           i_dim,
`endif
   hub75_bcm_scanner_if.master  bus
);

   localparam int unsigned ROW_AW = f_aw(ROWS / 2);
   localparam int unsigned COL_AW = f_aw(COLS);
   localparam int unsigned PL_W   = f_aw(BPC);
   localparam int unsigned DIV_W  = f_aw(CLK_DIV);
   localparam int unsigned ONT_W  = f_ont_w(BASE_OE, BPC);

   localparam logic [ROW_AW-1:0] ROW_MAX = ROW_AW'(ROWS / 2 - 1);
   localparam logic [COL_AW-1:0] COL_MAX = COL_AW'(COLS - 1);
   localparam logic [PL_W-1:0]   PL_MAX  = PL_W'(BPC - 1);
   localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

   state_e             r_state, w_state_d;
   phase_e             r_phase;
   logic [DIV_W-1:0]   r_div;
   logic [COL_AW-1:0]  r_col;
   logic [ROW_AW-1:0]  r_row;
   logic [ROW_AW-1:0]  r_addr;
   logic [PL_W-1:0]    r_plane;
   logic [1:0]         r_lat_cnt;
   logic [5:0]         r_rgb;
   logic               r_frame_done;

   logic               w_col_end;
   logic               w_lat_end;
   logic               w_tmr_load;
   logic               w_tmr_done;
   logic               w_oe_n;
   logic [5:0]         w_rgb_d;
   logic [BPC-1:0]     w_ch [6];

   // Channel words in output order {R0,G0,B0,R1,G1,B1}.
   assign w_ch[0] = bus.rd_data0[CH_R*BPC +: BPC];
   assign w_ch[1] = bus.rd_data0[CH_G*BPC +: BPC];
   assign w_ch[2] = bus.rd_data0[CH_B*BPC +: BPC];
   assign w_ch[3] = bus.rd_data1[CH_R*BPC +: BPC];
   assign w_ch[4] = bus.rd_data1[CH_G*BPC +: BPC];
   assign w_ch[5] = bus.rd_data1[CH_B*BPC +: BPC];

   always_comb begin
      w_rgb_d = '0;
      for (int i = 0; i < 6; i++) w_rgb_d[5-i] = w_ch[i][r_plane];
   end

   assign w_col_end  = (r_phase == PhLow) && (r_div == DIV_MAX) && (r_col == COL_MAX);
   assign w_lat_end  = (r_lat_cnt == 2'd2);
   assign w_tmr_load = (r_state == StLatch) && w_lat_end;

   hub75_bcm_timer #(
      .BASE_OE (BASE_OE),
      .ONT_W   (ONT_W),
      .PL_W    (PL_W)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_tmr_load),
      .i_plane (r_plane),
`ifdef GLOBAL_DIM_EN
      .i_dim   (i_dim),
`endif
      .o_oe_n  (w_oe_n),
      .o_done  (w_tmr_done)
   );

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_d;
   end

   // FSM next state; enable only matters when a full row pair has been shown
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (i_enable) w_state_d = StShift;
         StShift: if (w_col_end) w_state_d = StLatch;
         StLatch: if (w_lat_end) w_state_d = StShow;
         StShow: begin
            if (w_tmr_done) w_state_d = (r_plane != PL_MAX || i_enable) ? StShift : StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.rd_en    = 1'b0;
      bus.clk_shft = 1'b0;
      bus.lat      = 1'b0;
      unique case (r_state)
         StShift: begin
            bus.rd_en    = (r_phase == PhFetch);
            bus.clk_shft = (r_phase == PhHigh);
         end
         StLatch: bus.lat = !w_lat_end;
         default: ;
      endcase
   end

   // Datapath: column/plane/row counters, colour capture, latch address
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase      <= PhFetch;
         r_div        <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_addr       <= '0;
         r_plane      <= '0;
         r_lat_cnt    <= '0;
         r_rgb        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               r_phase   <= PhFetch;
               r_div     <= '0;
               r_col     <= '0;
               r_row     <= '0;
               r_plane   <= '0;
               r_lat_cnt <= '0;
            end
            StShift: begin
               unique case (r_phase)
                  PhFetch: r_phase <= PhLoad;
                  PhLoad: begin
                     r_rgb   <= w_rgb_d;
                     r_phase <= PhSetup;
                  end
                  PhSetup: r_phase <= PhHigh;
                  PhHigh: begin
                     if (r_div == DIV_MAX) begin
                        r_div   <= '0;
                        r_phase <= PhLow;
                     end else begin
                        r_div <= r_div + 1'b1;
                     end
                  end
                  PhLow: begin
                     if (r_div == DIV_MAX) begin
                        r_div   <= '0;
                        r_phase <= PhFetch;
                        if (r_col == COL_MAX) begin
                           r_col  <= '0;
                           r_addr <= r_row;
                        end else begin
                           r_col <= r_col + 1'b1;
                        end
                     end else begin
                        r_div <= r_div + 1'b1;
                     end
                  end
                  default: r_phase <= PhFetch;
               endcase
            end
            StLatch: r_lat_cnt <= r_lat_cnt + 1'b1;
            StShow: begin
               r_lat_cnt <= '0;
               if (w_tmr_done) begin
                  if (r_plane != PL_MAX) begin
                     r_plane <= r_plane + 1'b1;
                  end else begin
                     r_plane      <= '0;
                     r_row        <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
                     r_frame_done <= (r_row == ROW_MAX);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rd_row     = r_row;
   assign bus.rd_col     = r_col;
   assign bus.addr       = r_addr;
   assign bus.r0         = r_rgb[5];
   assign bus.g0         = r_rgb[4];
   assign bus.b0         = r_rgb[3];
   assign bus.r1         = r_rgb[2];
   assign bus.g1         = r_rgb[1];
   assign bus.b1         = r_rgb[0];
   assign bus.oe         = w_oe_n;
   assign bus.frame_done = r_frame_done;

endmodule
